// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI constants, the arbiter owner encoding and the address-phase payload.
// Imported by vscale_hasti_arb_port and vscale_hasti_arbiter.
package vscale_hasti_arbiter_pkg;

  localparam int unsigned HASTI_ADDR_WIDTH  = 32;
  localparam int unsigned HASTI_BUS_WIDTH   = 32;
  localparam int unsigned HASTI_SIZE_WIDTH  = 3;
  localparam int unsigned HASTI_BURST_WIDTH = 3;
  localparam int unsigned HASTI_PROT_WIDTH  = 4;
  localparam int unsigned HASTI_TRANS_WIDTH = 2;
  localparam int unsigned ARB_OWNER_WIDTH   = 2;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE = 3'b000;
  localparam logic                         HASTI_RESP_OKAY    = 1'b0;
  localparam logic                         HASTI_RESP_ERROR   = 1'b1;

  // Owner of the slave data phase.
  localparam logic [ARB_OWNER_WIDTH-1:0] ARB_OWNER_NONE = 2'd0;
  localparam logic [ARB_OWNER_WIDTH-1:0] ARB_OWNER_M0   = 2'd1;
  localparam logic [ARB_OWNER_WIDTH-1:0] ARB_OWNER_M1   = 2'd2;

  typedef struct packed {
    logic [HASTI_ADDR_WIDTH-1:0]  addr;
    logic                         write;
    logic [HASTI_SIZE_WIDTH-1:0]  size;
    logic [HASTI_BURST_WIDTH-1:0] burst;
    logic                         mastlock;
    logic [HASTI_PROT_WIDTH-1:0]  prot;
  } hasti_addr_phase_t;

  function automatic logic [ARB_OWNER_WIDTH-1:0] owner_of(input logic idx);
    return idx ? ARB_OWNER_M1 : ARB_OWNER_M0;
  endfunction

endpackage

// File: rtl/vscale_hasti_arb_port.sv
// One arbiter master port: request detection, single-entry address-phase hold
// register with pend_valid, and the held/live address-phase mux.
// Ports: clk, reset (async, active-high); live/htrans/hready = master bus as
// seen this cycle; accept = slave accepted this port's address phase;
// req = port wants the slave; pend_valid = a held phase is waiting;
// ctrl = address phase to present when granted.
module vscale_hasti_arb_port
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  hasti_addr_phase_t            live,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic                         hready,
  input  logic                         accept,
  output logic                         req,
  output logic                         pend_valid,
  output hasti_addr_phase_t            ctrl
);

  hasti_addr_phase_t hold;
  logic              live_req;

  // Reset gates the live request so the slave sees IDLE while in reset.
  assign live_req = !reset && (htrans == HASTI_TRANS_NONSEQ) && hready;
  assign req      = pend_valid || live_req;
  assign ctrl     = pend_valid ? hold : live;

  // Capture a live request that was not accepted; release on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      hold       <= '0;
    end else if (accept) begin
      pend_valid <= 1'b0;
    end else if (live_req) begin
      pend_valid <= 1'b1;
      hold       <= live;
    end
  end

  // Only SINGLE NONSEQ/IDLE traffic is supported.
  always_ff @(posedge clk) begin
    if (!reset && hready && (htrans != HASTI_TRANS_IDLE)) begin
      assert ((htrans == HASTI_TRANS_NONSEQ) && (live.burst == HASTI_BURST_SINGLE))
        else $error("vscale_hasti_arb_port: unsupported htrans/hburst");
    end
  end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (m0 = dmem, m1 = imem) to one-slave HASTI arbiter.
// Ports: clk, reset (async, active-high); m0_*/m1_* master request inputs and
// hrdata/hready/hresp response outputs; s_* slave address/wdata outputs and
// hrdata/hready/hresp inputs. Parameter DEFAULT_MASTER wins ties under fixed
// priority. Define VSCALE_HASTI_ARB_ROUND_ROBIN_EN for round-robin ties.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                         m0_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic                         m0_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                         m1_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic                         m1_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic                         s_hresp
);

  logic [ARB_OWNER_WIDTH-1:0] data_owner;
  logic                       lock_valid;
  logic                       lock_idx;
  logic                       grant_valid;
  logic                       grant_idx;
  logic                       tie_idx;
  logic [1:0]                 req;
  logic [1:0]                 pend;
  logic [1:0]                 accept;
  hasti_addr_phase_t          live0, live1, ctrl0, ctrl1, s_ctrl;

  assign live0 = '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize, burst: m0_hburst,
                   mastlock: m0_hmastlock, prot: m0_hprot};
  assign live1 = '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize, burst: m1_hburst,
                   mastlock: m1_hmastlock, prot: m1_hprot};

  // A pending master is stalled; the data-phase owner follows the slave.
  assign m0_hready = pend[0] ? 1'b0 : ((data_owner == ARB_OWNER_M0) ? s_hready : 1'b1);
  assign m1_hready = pend[1] ? 1'b0 : ((data_owner == ARB_OWNER_M1) ? s_hready : 1'b1);

  vscale_hasti_arb_port u_port0 (
    .clk(clk), .reset(reset), .live(live0), .htrans(m0_htrans), .hready(m0_hready),
    .accept(accept[0]), .req(req[0]), .pend_valid(pend[0]), .ctrl(ctrl0)
  );

  vscale_hasti_arb_port u_port1 (
    .clk(clk), .reset(reset), .live(live1), .htrans(m1_htrans), .hready(m1_hready),
    .accept(accept[1]), .req(req[1]), .pend_valid(pend[1]), .ctrl(ctrl1)
  );

`ifdef VSCALE_HASTI_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  assign tie_idx = rr_ptr;

  // Next tie goes to the master that did not just win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant_valid && s_hready) begin
      rr_ptr <= ~grant_idx;
    end
  end
`else
  assign tie_idx = (DEFAULT_MASTER != 0);
`endif

  // Grant: a stalled slave address phase keeps its owner, otherwise arbitrate.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (lock_valid) begin
      grant_valid = 1'b1;
      grant_idx   = lock_idx;
    end else if (req[0] && req[1]) begin
      grant_valid = 1'b1;
      grant_idx   = tie_idx;
    end else if (req[0]) begin
      grant_valid = 1'b1;
    end else if (req[1]) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end
  end

  assign accept[0] = grant_valid && !grant_idx && s_hready;
  assign accept[1] = grant_valid &&  grant_idx && s_hready;

  assign s_ctrl      = grant_valid ? (grant_idx ? ctrl1 : ctrl0) : '0;
  assign s_haddr     = s_ctrl.addr;
  assign s_hwrite    = s_ctrl.write;
  assign s_hsize     = s_ctrl.size;
  assign s_hburst    = s_ctrl.burst;
  assign s_hmastlock = s_ctrl.mastlock;
  assign s_hprot     = s_ctrl.prot;
  assign s_htrans    = grant_valid ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;

  // Data-phase ownership and the address-phase lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_owner <= ARB_OWNER_NONE;
      lock_valid <= 1'b0;
      lock_idx   <= 1'b0;
    end else if (s_hready) begin
      data_owner <= grant_valid ? owner_of(grant_idx) : ARB_OWNER_NONE;
      lock_valid <= 1'b0;
    end else if (grant_valid) begin
      lock_valid <= 1'b1;
      lock_idx   <= grant_idx;
    end
  end

  // Response and write-data routing by data-phase owner.
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hresp  = (data_owner == ARB_OWNER_M0) ? s_hresp : HASTI_RESP_OKAY;
  assign m1_hresp  = (data_owner == ARB_OWNER_M1) ? s_hresp : HASTI_RESP_OKAY;

  always_comb begin
    s_hwdata = '0;
    case (data_owner)
      ARB_OWNER_M0: s_hwdata = m0_hwdata;
      ARB_OWNER_M1: s_hwdata = m1_hwdata;
      default:      s_hwdata = '0;
    endcase
  end

  // A master is never pending while it owns the data phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pend[0] && (data_owner == ARB_OWNER_M0)))
        else $error("vscale_hasti_arbiter: m0 pending while owning data phase");
      assert (!(pend[1] && (data_owner == ARB_OWNER_M1)))
        else $error("vscale_hasti_arbiter: m1 pending while owning data phase");
    end
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: a queue of expected slave address
// phases is filled as masters are driven and drained as the slave accepts them.
module tb_vscale_hasti_arbiter;

`ifdef VSCALE_HASTI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [35:0] sb_q[$];   // {addr, write, size}

  always #5 clk = ~clk;

  vscale_hasti_arbiter #(.DEFAULT_MASTER(0)) dut (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w);
    sb_q.push_back({a, w, 3'b010});
  endtask

  // Score an accepted slave address phase, then advance to just past the next edge.
  task automatic cyc();
    logic [35:0] e;
    if (s_htrans === 2'b10 && s_hready === 1'b1) begin
      chk("issue_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("issue_addr", s_haddr, e[35:4]);
        chk("issue_ctl", 32'({s_hwrite, s_hsize}), 32'(e[3:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic [31:0] a, input logic w);
    m0_htrans = 2'b10; m0_haddr = a; m0_hwrite = w; m0_hsize = 3'b010;
    m0_hburst = 3'b000; m0_hprot = 4'b0011; m0_hmastlock = 1'b0;
  endtask

  task automatic m1_req(input logic [31:0] a, input logic w);
    m1_htrans = 2'b10; m1_haddr = a; m1_hwrite = w; m1_hsize = 3'b010;
    m1_hburst = 3'b000; m1_hprot = 4'b0010; m1_hmastlock = 1'b0;
  endtask

  // Idle bus with junk controls, so anything presented must come from a hold register.
  task automatic m0_idle();
    m0_htrans = 2'b00; m0_haddr = 32'hBAD0; m0_hwrite = 1'b1; m0_hsize = 3'b000;
    m0_hburst = 3'b000; m0_hprot = 4'hF; m0_hmastlock = 1'b0;
  endtask

  task automatic m1_idle();
    m1_htrans = 2'b00; m1_haddr = 32'hBAD1; m1_hwrite = 1'b1; m1_hsize = 3'b000;
    m1_hburst = 3'b000; m1_hprot = 4'hF; m1_hmastlock = 1'b0;
  endtask

  initial begin
    logic [31:0] a0, a1;
    logic        h0, h1;
    reset = 1'b1; m0_idle(); m1_idle(); m0_hwdata = '0; m1_hwdata = '0;
    s_hrdata = '0; s_hready = 1'b1; s_hresp = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    chk("rst_htrans", 32'(s_htrans), 32'd0);
    chk("rst_haddr", s_haddr, 32'd0);
    chk("rst_hwdata", s_hwdata, 32'd0);
    chk("rst_m0_hready", 32'(m0_hready), 32'd1);
    chk("rst_m1_hready", 32'(m1_hready), 32'd1);
    chk("rst_hresp", 32'({m0_hresp, m1_hresp}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single master read, zero wait states
    m1_req(32'h100, 1'b0); push(32'h100, 1'b0); #2;
    chk("single_haddr", s_haddr, 32'h100);
    chk("single_htrans", 32'(s_htrans), 32'd2);
    chk("single_m1_hready", 32'(m1_hready), 32'd1);
    cyc();
    m1_idle(); s_hrdata = 32'hCAFE0100; #2;
    chk("single_rdata", m1_hrdata, 32'hCAFE0100);
    chk("single_data_hready", 32'(m1_hready), 32'd1);
    cyc();

    // Collision: m0 write 0x200 (then 0x204) against m1 read 0x300
    m0_req(32'h200, 1'b1); m1_req(32'h300, 1'b0);
    push(32'h200, 1'b1);
    if (RR) begin push(32'h300, 1'b0); push(32'h204, 1'b1); end
    else    begin push(32'h204, 1'b1); push(32'h300, 1'b0); end
    #2;
    chk("coll_a_haddr", s_haddr, 32'h200);
    chk("coll_a_m1_hready", 32'(m1_hready), 32'd1);
    cyc();
    m0_req(32'h204, 1'b1); m0_hwdata = 32'hDEADBEEF; m1_idle(); #2;
    chk("coll_b_hwdata", s_hwdata, 32'hDEADBEEF);
    chk("coll_b_haddr", s_haddr, RR ? 32'h300 : 32'h204);
    chk("coll_b_m1_hready", 32'(m1_hready), 32'd0);
    cyc();
    m0_idle(); m0_hwdata = 32'h12345678; #2;
    chk("coll_c_haddr", s_haddr, RR ? 32'h204 : 32'h300);
    chk("coll_c_hprot", 32'(s_hprot), RR ? 32'd3 : 32'd2);
    chk("coll_c_hsize", 32'(s_hsize), 32'd2);
    chk("coll_c_m1_hready", 32'(m1_hready), RR ? 32'd1 : 32'd0);
    chk("coll_c_hwdata", s_hwdata, RR ? 32'd0 : 32'h12345678);
    cyc();
    #2;
    chk("coll_d_m1_hready", 32'(m1_hready), 32'd1);
    chk("coll_d_htrans", 32'(s_htrans), 32'd0);
    cyc();

    // Wait states: slave stalls m0's data phase while m1 requests
    m0_req(32'h400, 1'b0); push(32'h400, 1'b0); push(32'h500, 1'b0); #2;
    cyc();
    m0_idle(); m1_req(32'h500, 1'b0); s_hready = 1'b0; #2;
    chk("ws_m1_hready", 32'(m1_hready), 32'd1);
    chk("ws_m0_hready", 32'(m0_hready), 32'd0);
    chk("ws0_haddr", s_haddr, 32'h500);
    cyc();
    m1_idle();
    for (int i = 1; i < 3; i++) begin
      #2;
      chk("ws_haddr", s_haddr, 32'h500);
      chk("ws_htrans", 32'(s_htrans), 32'd2);
      chk("ws_m1_stall", 32'(m1_hready), 32'd0);
      cyc();
    end
    s_hready = 1'b1; s_hrdata = 32'h0400_0400; #2;
    chk("ws_release_haddr", s_haddr, 32'h500);
    chk("ws_release_m0_hready", 32'(m0_hready), 32'd1);
    chk("ws_release_m0_rdata", m0_hrdata, 32'h0400_0400);
    cyc();
    #2;
    chk("ws_done_m1_hready", 32'(m1_hready), 32'd1);
    cyc();

    // ERROR response to m0
    m0_req(32'hFFF0, 1'b0); push(32'hFFF0, 1'b0); #2;
    cyc();
    m0_idle(); s_hready = 1'b0; s_hresp = 1'b1; #2;
    chk("err1_m0_hresp", 32'(m0_hresp), 32'd1);
    chk("err1_m1_hresp", 32'(m1_hresp), 32'd0);
    chk("err1_m0_hready", 32'(m0_hready), 32'd0);
    cyc();
    s_hready = 1'b1; #2;
    chk("err2_m0_hresp", 32'(m0_hresp), 32'd1);
    chk("err2_m1_hresp", 32'(m1_hresp), 32'd0);
    chk("err2_m0_hready", 32'(m0_hready), 32'd1);
    cyc();
    s_hresp = 1'b0; #2;
    chk("err_done_m0_hresp", 32'(m0_hresp), 32'd0);
    cyc();

    // Reset while m1 holds a pending address phase
    m0_req(32'h600, 1'b0); push(32'h600, 1'b0); #2;
    cyc();
    m0_idle(); m1_req(32'h700, 1'b0); s_hready = 1'b0; #2;
    chk("rstp_haddr", s_haddr, 32'h700);
    cyc();
    m1_idle(); #1;
    chk("rstp_pending", 32'(m1_hready), 32'd0);
    reset = 1'b1; #1;
    chk("rstp_m1_hready", 32'(m1_hready), 32'd1);
    chk("rstp_m0_hready", 32'(m0_hready), 32'd1);
    chk("rstp_htrans", 32'(s_htrans), 32'd0);
    cyc();
    reset = 1'b0; s_hready = 1'b1; #2;
    chk("rstp_after_htrans", 32'(s_htrans), 32'd0);
    cyc();

    // Both masters stream reads back to back
    if (RR) begin
      push(32'h1000, 1'b0); push(32'h2000, 1'b0); push(32'h1004, 1'b0); push(32'h2004, 1'b0);
      push(32'h1008, 1'b0); push(32'h2008, 1'b0); push(32'h100C, 1'b0);
    end else begin
      for (int i = 0; i < 6; i++) push(32'h1000 + 32'(4 * i), 1'b0);
      push(32'h2000, 1'b0);
    end
    a0 = 32'h1000; a1 = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      m0_req(a0, 1'b0); m1_req(a1, 1'b0); #2;
      h0 = m0_hready; h1 = m1_hready;
      cyc();
      if (h0) a0 = a0 + 32'd4;
      if (h1) a1 = a1 + 32'd4;
    end
    m0_idle(); m1_idle();
    for (int k = 0; k < 3; k++) begin
      #2;
      cyc();
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_arbiter.md
# vscale_hasti_arbiter

Two-master to one-slave HASTI (AHB-Lite) arbiter that lets the imem and dmem bridges share a single memory port, e.g. one unified SRAM or an external bus. It sits between the two bridge master ports and the slave. It forwards address phases, routes data-phase responses back to the owning master, and buffers at most one address phase per master when that master loses arbitration. Only SINGLE bursts and NONSEQ/IDLE transfers occur on this core's buses.

## Interface
- DEFAULT_MASTER, 0: master whose pending request wins ties under fixed priority (0 = dmem port, 1 = imem port).
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hmastlock, m0_hprot, m0_htrans, m0_hwdata  in  32/1/3/3/1/4/2/32  master 0 (dmem) request.
- m0_hrdata  out  32  read data (broadcast of s_hrdata).
- m0_hready  out  1  master 0 ready.
- m0_hresp  out  1  master 0 response.
- m1_*  same set  master 1 (imem).
- s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata  out  32/1/3/3/1/4/2/32  to slave.
- s_hrdata  in  32; s_hready  in  1; s_hresp  in  1  from slave.

## Operation
Per-master state:
- pend_valid[i] plus a hold register (addr, write, size, burst, prot, mastlock).

Global state:
- data_owner ∈ {NONE, M0, M1}: owner of the slave data phase.
- lock_valid/lock_idx: issued slave address phase not yet accepted.
- rr_ptr: round-robin pointer, present only with the macro.

Request from master i: pend_valid[i], or m_i_htrans==NONSEQ with m_i_hready==1.

Grant:
- If lock_valid, the grant stays with lock_idx.
- Otherwise, select by policy among requesters.
- s_* address controls come from the grantee's hold register if pend_valid, else from its live bus.
- s_htrans = NONSEQ on grant, IDLE otherwise.

On s_hready==1, the slave address phase is accepted:
- data_owner <= grantee (or NONE).
- Grantee pend cleared.
- lock cleared.

On s_hready==0 with a grant: lock_valid <= 1, lock_idx <= grantee.

Capture:
- A live request with m_i_hready==1 that is not accepted this cycle (not granted, or s_hready==0) loads the hold register and sets pend_valid[i].

Master hready:
- m_i_hready = 0 if pend_valid[i].
- Else s_hready if data_owner==i.
- Else 1.

Response and write-data routing:
- m_i_hresp = s_hresp when data_owner==i, else OKAY.
- s_hwdata = hwdata of data_owner (0 when NONE).

Invariant: a master never has pend_valid and data_owner==i at once. Assert this in simulation.

ERROR responses (two-cycle) are forwarded unchanged to the owner. A cancel (IDLE) issued in the second cycle is honoured because that master holds no pend.

hmastlock is forwarded only and has no arbitration effect. Non-SINGLE bursts and SEQ/BUSY transfers are unsupported; a simulation assertion fires on them.

## Timing
- Reset values: s_htrans=IDLE, other s_* controls=0, s_hwdata=0, m*_hready=1, m*_hresp=OKAY, data_owner=NONE, no pend, no lock, rr_ptr=0.
- Uncontended: zero added latency. The address is combinationally forwarded the same cycle, and hready/hresp are passthrough.
- Contended: the loser is captured that cycle and is issued at the earliest s_hready==1 cycle on which it wins. Its m_hready stays 0 until its buffered data phase completes.
- Simultaneous pending plus a new live request from the other master resolves by policy. A pending request and a live request never come from the same master.
- Reset mid-transfer: all state drops immediately, and the outstanding slave transfer is abandoned.

## Configuration
- VSCALE_HASTI_ARB_ROUND_ROBIN_EN defined:
  - Round-robin between masters.
  - rr_ptr points to the master that wins the next tie.
  - rr_ptr advances past the grantee on each accepted address phase.
- Undefined:
  - Fixed priority, with DEFAULT_MASTER winning ties.
  - No rr_ptr flop.

## Structure
- Add to the shared vscale_hasti_constants header:
  - HTRANS encodings IDLE=2'b00, NONSEQ=2'b10.
  - HRESP OKAY/ERROR.
  - Widths.
  - Owner encoding (ARB_OWNER_NONE/M0/M1).
- Sub-module vscale_hasti_arb_port, instantiated twice:
  - Contains the hold register, pend_valid, request detection, and the live/held mux.
- The top module holds grant, lock, data_owner, the response/wdata muxing and rr_ptr.

## Test plan
- Single master: m1 reads 0x100, slave has zero wait states, m0 idle -> s_haddr=0x100 the same cycle; m1_hready=1 and data returned next cycle.
- Collision: m0 write 0x200 data 0xDEADBEEF and m1 read 0x300 in the same cycle, fixed priority, DEFAULT_MASTER=0 ->
  - m0 issued first and the slave receives 0xDEADBEEF.
  - m1 captured; m1_hready=0 for 2 cycles.
  - 0x300 is issued with unchanged control signals.
- Wait states: the slave holds s_hready=0 for 3 cycles while m1 requests -> s_haddr and s_htrans remain stable across all stall cycles; m1 is captured and issued afterwards.
- Round robin (macro on): both masters issue back-to-back reads continuously -> grants alternate M0, M1, M0, M1.
- Error: the slave returns ERROR to m0's read 0xFFF0 -> m0_hresp=1 for 2 cycles; m1_hresp stays 0.
- Reset asserted while m1 is pending -> within the same cycle pend is cleared, m1_hready=1 and s_htrans=IDLE.
